// File: rtl/rf_encoder.sv
// rtl/rf_encoder.sv - byte-serial Manchester / Miller / FM0 line encoder, one clk2x cycle per half-bit
//
// Optional preamble: define RF_ENCODER_PREAMBLE_EN to send PREAMBLE_BITS '0' bits
// before the first byte of every burst (never between chained bytes).
//
// Ports:
//   clk2x      half-bit-rate clock, all logic on its rising edge
//   rst_n      synchronous reset, active-low
//   enable     1 = may accept new bytes
//   mode       0 Manchester, 1 Miller, 2 FM0, 3 Manchester; sampled at burst start only
//   din        byte to send, MSB first
//   din_valid  din is valid
//   din_ready  encoder accepts din this cycle
//   dout       registered line output
//   busy       burst in progress
module rf_encoder #(
    parameter logic IDLE_LEVEL    = 1'b0,
    parameter int   PREAMBLE_BITS = 8
) (
    input  logic       clk2x,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       dout,
    output logic       busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd2;
`ifdef RF_ENCODER_PREAMBLE_EN
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam int PC_W = $clog2(PREAMBLE_BITS + 1);
    logic [PC_W-1:0] r_precnt;
`else
    logic w_unused_preamble;
    assign w_unused_preamble = (PREAMBLE_BITS != 0);
`endif

    logic [1:0] r_state;
    logic [1:0] r_mode;
    logic [7:0] r_shift;    // r_shift[7] is the next bit to start
    logic [2:0] r_bitcnt;   // index of the bit currently on the line
    logic       r_phase;    // 0 = first half on the line, 1 = second half
    logic       r_second;   // second-half level of the current bit
    logic       r_level;    // line level L carried into the next bit
    logic       r_prev;     // previous data bit (Miller rule)
    logic       r_dout;

    logic       w_accept;
    logic       w_start;
    logic       w_bit;
    logic       w_l;
    logic       w_p;
    logic [1:0] w_mode;
    logic [1:0] w_halves;

    // Returns {first half, second half} for data bit b given line level l and previous bit p.
    function automatic logic [1:0] encode(input logic [1:0] m, input logic b,
                                          input logic l, input logic p);
        logic f;
        logic s;
        case (m)
            2'd1: begin
                f = (~b & ~p) ? ~l : l;
                s = b ? ~f : f;
            end
            2'd2: begin
                f = ~l;
                s = b ? f : ~f;
            end
            default: begin   // Manchester, also used for reserved mode 3
                f = b;
                s = ~b;
            end
        endcase
        return {f, s};
    endfunction

    // Gated by rst_n so a handshake can never coincide with reset.
    assign din_ready = rst_n & enable &
                       ((r_state == S_IDLE) |
                        ((r_state == S_DATA) & r_phase & (r_bitcnt == 3'd0)));
    assign w_accept  = din_valid & din_ready;
    assign dout      = r_dout;
    assign busy      = (r_state != S_IDLE);

    // Selects the bit (and its encoding context) that begins on the next cycle, if any.
    always_comb begin
        w_start = 1'b0;
        w_bit   = 1'b0;
        w_mode  = r_mode;
        w_l     = r_level;
        w_p     = r_prev;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_start = 1'b1;
                    w_mode  = mode;
                    w_l     = IDLE_LEVEL;
                    w_p     = 1'b1;
`ifdef RF_ENCODER_PREAMBLE_EN
                    w_bit   = 1'b0;
`else
                    w_bit   = din[7];
`endif
                end
            end
`ifdef RF_ENCODER_PREAMBLE_EN
            S_PRE: begin
                if (r_phase) begin
                    w_start = 1'b1;
                    w_bit   = (r_precnt != '0) ? 1'b0 : r_shift[7];
                end
            end
`endif
            S_DATA: begin
                if (r_phase && r_bitcnt != 3'd0) begin
                    w_start = 1'b1;
                    w_bit   = r_shift[7];
                end else if (r_phase && w_accept) begin
                    w_start = 1'b1;
                    w_bit   = din[7];
                end
            end
            default: ;
        endcase
        w_halves = encode(w_mode, w_bit, w_l, w_p);
    end

    always_ff @(posedge clk2x) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_mode   <= 2'd0;
            r_shift  <= 8'd0;
            r_bitcnt <= 3'd0;
            r_phase  <= 1'b0;
            r_second <= IDLE_LEVEL;
            r_level  <= IDLE_LEVEL;
            r_prev   <= 1'b1;
            r_dout   <= IDLE_LEVEL;
`ifdef RF_ENCODER_PREAMBLE_EN
            r_precnt <= '0;
`endif
        end else begin
            if (w_start) begin
                r_dout   <= w_halves[1];
                r_second <= w_halves[0];
                r_level  <= w_halves[0];
                r_prev   <= w_bit;
                r_phase  <= 1'b0;
            end else if (r_state != S_IDLE && !r_phase) begin
                r_dout  <= r_second;
                r_phase <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mode <= mode;
`ifdef RF_ENCODER_PREAMBLE_EN
                        r_state  <= S_PRE;
                        r_shift  <= din;
                        r_precnt <= PC_W'(PREAMBLE_BITS - 1);
`else
                        r_state  <= S_DATA;
                        r_shift  <= {din[6:0], 1'b0};
                        r_bitcnt <= 3'd7;
`endif
                    end
                end
`ifdef RF_ENCODER_PREAMBLE_EN
                S_PRE: begin
                    if (r_phase) begin
                        if (r_precnt != '0) begin
                            r_precnt <= r_precnt - 1'b1;
                        end else begin
                            r_state  <= S_DATA;
                            r_shift  <= {r_shift[6:0], 1'b0};
                            r_bitcnt <= 3'd7;
                        end
                    end
                end
`endif
                S_DATA: begin
                    if (r_phase) begin
                        if (r_bitcnt != 3'd0) begin
                            r_bitcnt <= r_bitcnt - 3'd1;
                            r_shift  <= {r_shift[6:0], 1'b0};
                        end else if (w_accept) begin
                            r_bitcnt <= 3'd7;
                            r_shift  <= {din[6:0], 1'b0};
                        end else begin
                            r_state <= S_IDLE;
                            r_dout  <= IDLE_LEVEL;
                            r_phase <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_encoder.sv
// tb/tb_rf_encoder.sv - directed vector bench for rf_encoder
module tb_rf_encoder;

`ifdef RF_ENCODER_PREAMBLE_EN
    localparam int              PB     = 4;
    localparam int              PRE_H  = 2 * PB;
    localparam logic [1:0]      MODE_R = 2'd0;
    localparam logic [15:0]     EXP_R  = 16'h9966;
`else
    localparam int              PB     = 4;
    localparam int              PRE_H  = 0;
    localparam logic [1:0]      MODE_R = 2'd1;
    localparam logic [15:0]     EXP_R  = 16'h78E1;
`endif

    logic       clk2x;
    logic       rst_n;
    logic       enable;
    logic [1:0] mode;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       dout;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    rf_encoder #(.IDLE_LEVEL(1'b0), .PREAMBLE_BITS(PB)) dut (
        .clk2x    (clk2x),
        .rst_n    (rst_n),
        .enable   (enable),
        .mode     (mode),
        .din      (din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .dout     (dout),
        .busy     (busy)
    );

    initial clk2x = 1'b0;
    always #5 clk2x = ~clk2x;

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  din;
        logic        drop_en;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk2x);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sends one byte from IDLE and checks its 16 half-bits, busy, din_ready and the return to idle.
    task automatic run_byte(input string name, input logic [1:0] m, input logic [7:0] d,
                            input logic drop_en, input logic [15:0] exp);
        logic [15:0] seq;
        logic [15:0] rdy;
        logic        busy_all;
        seq = '0;
        rdy = '0;
        busy_all = 1'b1;
        mode = m;
        din = d;
        din_valid = 1'b1;
        enable = 1'b1;
        #1;
        chk({name, " ready_idle"}, {31'd0, din_ready}, 32'd1);
        tick();
        din_valid = 1'b0;
        din = ~d;
        mode = ~m;
        if (drop_en) enable = 1'b0;
        repeat (PRE_H) tick();
        #1;
        for (int i = 0; i < 16; i++) begin
            seq[15-i] = dout;
            rdy[15-i] = din_ready;
            busy_all  = busy_all & busy;
            tick();
        end
        chk({name, " halves"}, {16'd0, seq}, {16'd0, exp});
        chk({name, " busy"}, {31'd0, busy_all}, 32'd1);
        chk({name, " ready"}, {16'd0, rdy}, drop_en ? 32'd0 : 32'd1);
        chk({name, " idle_dout"}, {31'd0, dout}, 32'd0);
        chk({name, " idle_busy"}, {31'd0, busy}, 32'd0);
        enable = 1'b1;
    endtask

    initial begin
        logic [31:0] seq32;
        logic [31:0] rdy32;

        vecs[0] = '{2'd0, 8'hA5, 1'b0, 16'h9966};
        vecs[1] = '{2'd1, 8'hA5, 1'b0, 16'h78E1};
        vecs[2] = '{2'd2, 8'hA5, 1'b0, 16'hD2B4};
        vecs[3] = '{2'd3, 8'hA5, 1'b0, 16'h9966};
        vecs[4] = '{2'd1, 8'h00, 1'b0, 16'h3333};
        vecs[5] = '{2'd2, 8'hFF, 1'b0, 16'hCCCC};
        vecs[6] = '{2'd0, 8'h3C, 1'b1, 16'h5AA5};
        vecs[7] = '{2'd1, 8'hFF, 1'b1, 16'h6666};
        vecs[8] = '{2'd2, 8'h00, 1'b0, 16'hAAAA};

        rst_n = 1'b0;
        enable = 1'b0;
        mode = 2'd0;
        din = 8'h00;
        din_valid = 1'b0;
        tick();
        tick();
        chk("reset dout", {31'd0, dout}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset ready", {31'd0, din_ready}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 9; v++) begin
`ifdef RF_ENCODER_PREAMBLE_EN
            if (vecs[v].mode == 2'd1 || vecs[v].mode == 2'd2) continue;
`endif
            run_byte($sformatf("vec%0d", v), vecs[v].mode, vecs[v].din, vecs[v].drop_en, vecs[v].exp);
            tick();
        end

        // Back-to-back Manchester 0xFF then 0x00 with din_valid held.
        mode = 2'd0;
        din = 8'hFF;
        din_valid = 1'b1;
        enable = 1'b1;
        #1;
        tick();
        din = 8'h00;
        mode = 2'd1;
        repeat (PRE_H) tick();
        #1;
        seq32 = '0;
        rdy32 = '0;
        for (int c = 1; c <= 32; c++) begin
            seq32[32-c] = dout;
            rdy32[32-c] = din_ready;
            tick();
            if (c == 16) begin
                enable = 1'b0;
                din_valid = 1'b0;
                #1;
            end
        end
        chk("b2b halves", seq32, 32'hAAAA5555);
        chk("b2b ready", rdy32, 32'h00010000);
        chk("b2b idle_busy", {31'd0, busy}, 32'd0);
        enable = 1'b1;
        tick();

        // Reset mid-burst, then a fresh byte.
        mode = MODE_R;
        din = 8'h00;
        din_valid = 1'b1;
        #1;
        tick();
        din_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        #1;
        chk("midreset dout", {31'd0, dout}, 32'd0);
        chk("midreset busy", {31'd0, busy}, 32'd0);
        chk("midreset ready", {31'd0, din_ready}, 32'd0);
        rst_n = 1'b1;
        tick();
        run_byte("after_reset", MODE_R, 8'hA5, 1'b0, EXP_R);
        tick();

        // Reset coincident with a handshake: nothing is accepted.
        rst_n = 1'b0;
        din = 8'hFF;
        din_valid = 1'b1;
        tick();
        rst_n = 1'b1;
        din_valid = 1'b0;
        #1;
        chk("rst_hs busy", {31'd0, busy}, 32'd0);
        tick();
        chk("rst_hs busy2", {31'd0, busy}, 32'd0);
        chk("rst_hs dout", {31'd0, dout}, 32'd0);

`ifdef RF_ENCODER_PREAMBLE_EN
        // Preamble: four Manchester '0' bits, then 0x80.
        mode = 2'd0;
        din = 8'h80;
        din_valid = 1'b1;
        enable = 1'b1;
        #1;
        tick();
        din_valid = 1'b0;
        #1;
        seq32 = '0;
        rdy32 = '0;
        for (int c = 1; c <= 24; c++) begin
            seq32[24-c] = dout;
            rdy32[24-c] = din_ready;
            tick();
        end
        chk("pre halves", seq32, 32'h00559555);
        chk("pre ready", rdy32, 32'h00000001);
        chk("pre idle_busy", {31'd0, busy}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
